// File: rtl/scanline_pixel_reader_pkg.sv
// Shared constants and state encoding for the scanline read path.
// Also imported by the fetch/write side of the scanline buffers.
package scanline_pixel_reader_pkg;

   localparam int DEF_NUM_BYTES = 20;
   localparam int DEF_ADDR_W    = 5;
   localparam int PIX_PER_LINE  = 8 * DEF_NUM_BYTES;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/scanline_pixel_reader_if.sv
// Pixel stream from the scanline reader to the LCD/palette stage.
// Transfer happens when pix_valid and pix_ready are both high at posedge.
interface scanline_pixel_reader_if;

   logic       pix_valid;
   logic       pix_ready;
   logic [1:0] pix_data;
   logic       pix_last;

   modport master (
      output pix_valid,
      output pix_data,
      output pix_last,
      input  pix_ready
   );

   modport slave (
      input  pix_valid,
      input  pix_data,
      input  pix_last,
      output pix_ready
   );

endinterface

// File: rtl/scanline_plane_shifter.sv
// Low/high plane byte pair shifter with a 3-bit bit counter.
// Emits {hi[7], lo[7]} as the current 2-bit pixel.
module scanline_plane_shifter (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] din_lo,
   input  logic [7:0] din_hi,
   output logic [1:0] pix,
   output logic [2:0] bit_cnt
);

   logic [7:0] sh_lo;
   logic [7:0] sh_hi;
   logic [2:0] cnt;

   // load beats shift: a reload on bit 7 replaces the drained byte
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_lo <= 8'd0;
         sh_hi <= 8'd0;
         cnt   <= 3'd0;
      end else if (clear) begin
         sh_lo <= 8'd0;
         sh_hi <= 8'd0;
         cnt   <= 3'd0;
      end else if (load) begin
         sh_lo <= din_lo;
         sh_hi <= din_hi;
         cnt   <= 3'd0;
      end else if (shift) begin
         sh_lo <= {sh_lo[6:0], 1'b0};
         sh_hi <= {sh_hi[6:0], 1'b0};
         cnt   <= cnt + 3'd1;
      end
   end

   assign pix     = {sh_hi[7], sh_lo[7]};
   assign bit_cnt = cnt;

endmodule

// File: rtl/scanline_pixel_reader.sv
// Walks both plane buffers and streams 2-bit pixels MSB-first,
// one pixel per cycle while the consumer is ready.
module scanline_pixel_reader
   import scanline_pixel_reader_pkg::*;
#(
   parameter int NUM_BYTES = DEF_NUM_BYTES,
   parameter int ADDR_W    = DEF_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [7:0]            rd_data_lo,
   input  logic [7:0]            rd_data_hi,
   scanline_pixel_reader_if.master pix,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR =
      ADDR_W'(NUM_BYTES - 1);

   state_t     state;
   state_t     state_nxt;
   logic       load;
   logic       shift;
   logic       clear;
   logic       xfer;
   logic       last_byte;
   logic       valid_q;
   logic [2:0] bit_cnt;
   logic [1:0] pix_bits;

   assign xfer = valid_q & pix.pix_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      clear     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !abort) state_nxt = LOAD;
         end
         LOAD: begin
            if (abort) begin
               clear     = 1'b1;
               state_nxt = IDLE;
            end else begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               clear     = 1'b1;
               state_nxt = IDLE;
            end else if (xfer) begin
               if (bit_cnt == 3'd7 && last_byte) begin
                  shift     = 1'b1;
                  state_nxt = DONE;
               end else if (bit_cnt == 3'd7) begin
                  load      = 1'b1;
               end else begin
                  shift     = 1'b1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // address points at the next byte to load; it parks on the last one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_addr   <= '0;
         last_byte <= 1'b0;
         valid_q   <= 1'b0;
         done      <= 1'b0;
      end else begin
         valid_q <= (state_nxt == SHIFT);
         done    <= (state_nxt == DONE);
         if (state_nxt == IDLE) begin
            rd_addr   <= '0;
            last_byte <= 1'b0;
         end else if (load) begin
            last_byte <= (rd_addr == LAST_ADDR);
            if (rd_addr != LAST_ADDR)
               rd_addr <= rd_addr + 1'b1;
         end
      end
   end

   scanline_plane_shifter u_shifter (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .load    (load),
      .shift   (shift),
      .din_lo  (rd_data_lo),
      .din_hi  (rd_data_hi),
      .pix     (pix_bits),
      .bit_cnt (bit_cnt)
   );

   assign pix.pix_valid = valid_q;
   assign pix.pix_data  = pix_bits;
   assign pix.pix_last  =
      last_byte & (bit_cnt == 3'd7) & valid_q;
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_scanline_pixel_reader.sv
// Randomized bench for scanline_pixel_reader against a
// byte-array pixel model of the two plane buffers.
module tb_scanline_pixel_reader;
   import scanline_pixel_reader_pkg::*;

   localparam int NB   = DEF_NUM_BYTES;
   localparam int NPIX = 8 * NB;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic                  abort;
   logic                  ready;
   logic [DEF_ADDR_W-1:0] rd_addr;
   logic [7:0]            rd_data_lo;
   logic [7:0]            rd_data_hi;
   logic                  busy;
   logic                  done;

   logic [7:0] lo_mem [NB];
   logic [7:0] hi_mem [NB];

   scanline_pixel_reader_if pif ();

   assign pif.pix_ready = ready;
   assign rd_data_lo = (int'(rd_addr) < NB) ? lo_mem[rd_addr] : 8'h00;
   assign rd_data_hi = (int'(rd_addr) < NB) ? hi_mem[rd_addr] : 8'h00;

   scanline_pixel_reader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .rd_addr    (rd_addr),
      .rd_data_lo (rd_data_lo),
      .rd_data_hi (rd_data_hi),
      .pix        (pif),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   logic [1:0] exp_q [$];
   logic [1:0] got [$];
   int         lasts [$];
   bit         rdy_hist [$];
   int done_cnt, done_cyc, stall_err, addr_err, stall_n, fired;

   // pixel k of byte b is bit (7-k) of each plane, hi plane in bit 1
   function automatic void build_model();
      exp_q.delete();
      for (int b = 0; b < NB; b++)
         for (int k = 7; k >= 0; k--)
            exp_q.push_back({hi_mem[b][k], lo_mem[b][k]});
   endfunction

   function automatic int seq_errs();
      int e = 0;
      if (got.size() != exp_q.size()) e++;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         if (got[i] !== exp_q[i]) e++;
      return e;
   endfunction

   // first transfer possible two edges after start is sampled
   function automatic int exp_done_cyc();
      int cnt = 0;
      for (int c = 2; c < rdy_hist.size(); c++) begin
         if (rdy_hist[c]) cnt++;
         if (cnt == NPIX) return c + 1;
      end
      return -2;
   endfunction

   function automatic void fill_random();
      for (int i = 0; i < NB; i++) begin
         lo_mem[i] = 8'($urandom);
         hi_mem[i] = 8'($urandom);
      end
   endfunction

   task automatic start_line();
      @(posedge clk); #1;
      start = 1'b1;
   endtask

   task automatic run(input int max_cyc, input int mode,
                      input int stop_pix);
      logic       pv, pr, pl;
      logic [1:0] pd;
      pv = 0; pr = 0; pl = 0; pd = 0;
      got.delete(); lasts.delete(); rdy_hist.delete();
      done_cnt = 0; done_cyc = -1; stall_err = 0;
      addr_err = 0; stall_n = 0; fired = 0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         rdy_hist.push_back(ready);
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (pv && !pr)
            if (!pif.pix_valid || pif.pix_data !== pd ||
                pif.pix_last !== pl) stall_err++;
         if (mode == 3 && pif.pix_valid && !ready &&
             rd_addr !== 5'd5) addr_err++;
         if (pif.pix_valid && ready) begin
            got.push_back(pif.pix_data);
            if (pif.pix_last) lasts.push_back(got.size() - 1);
         end
         pv = pif.pix_valid; pr = ready;
         pd = pif.pix_data;  pl = pif.pix_last;
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         case (mode)
            1: ready = ~ready;
            2: ready = 1'($urandom_range(0, 1));
            3: begin
               if (got.size() == 39 && stall_n < 10) begin
                  ready = 1'b0;
                  stall_n++;
               end else ready = 1'b1;
            end
            4: begin
               ready = 1'b1;
               if (fired == 0 && got.size() == 0) begin
                  start = 1'b1; fired++;
               end else if (fired == 1 && got.size() == 80) begin
                  start = 1'b1; fired++;
               end else if (fired == 2 && got.size() == 159) begin
                  start = 1'b1; fired++;
               end else if (fired == 3 && got.size() == 160) begin
                  start = 1'b1; fired++;
               end
            end
            default: ready = 1'b1;
         endcase
         if (stop_pix > 0 && got.size() >= stop_pix) break;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
      for (int i = 0; i < NB; i++) begin
         lo_mem[i] = 8'h00; hi_mem[i] = 8'h00;
      end
      #12;
      total++;
      if ({rd_addr, pif.pix_valid, pif.pix_data, pif.pix_last,
           busy, done} !== '0)
         $display("FAIL reset_vals: addr=%0d v=%b d=%b l=%b b=%b dn=%b need all 0",
                  rd_addr, pif.pix_valid, pif.pix_data, pif.pix_last,
                  busy, done);
      else pass_cnt++;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_ramp();
      for (int i = 0; i < NB; i++) begin
         lo_mem[i] = 8'(i);
         hi_mem[i] = ~8'(i);
      end
      build_model();
      ready = 1'b1;
      start_line();
      run(200, 0, 0);
      total++;
      if (seq_errs() != 0)
         $display("FAIL ramp_seq: %0d pixel errors of %0d got, need 0",
                  seq_errs(), got.size());
      else pass_cnt++;
      total++;
      if (lasts.size() != 1 || lasts[0] != NPIX - 1)
         $display("FAIL ramp_last: %0d last pulses first at %0d, need 1 at %0d",
                  lasts.size(), lasts.size() ? lasts[0] : -1, NPIX - 1);
      else pass_cnt++;
      total++;
      if (done_cyc != NPIX + 2)
         $display("FAIL ramp_done_time: cycle %0d, need %0d",
                  done_cyc, NPIX + 2);
      else pass_cnt++;
      total++;
      if (done_cnt != 1)
         $display("FAIL ramp_done_cnt: %0d pulses, need 1", done_cnt);
      else pass_cnt++;
   endtask

   task automatic test_toggle();
      for (int i = 0; i < NB; i++) begin
         lo_mem[i] = 8'hA5; hi_mem[i] = 8'h0F;
      end
      build_model();
      ready = 1'b1;
      start_line();
      run(400, 1, 0);
      total++;
      if (seq_errs() != 0)
         $display("FAIL toggle_seq: %0d pixel errors, need 0", seq_errs());
      else pass_cnt++;
      total++;
      if (stall_err != 0)
         $display("FAIL toggle_stable: %0d unstable stalls, need 0",
                  stall_err);
      else pass_cnt++;
      total++;
      if (done_cyc != exp_done_cyc() || done_cnt != 1)
         $display("FAIL toggle_done: cycle %0d count %0d, need cycle %0d count 1",
                  done_cyc, done_cnt, exp_done_cyc());
      else pass_cnt++;
   endtask

   task automatic test_stall();
      fill_random();
      build_model();
      ready = 1'b1;
      start_line();
      run(250, 3, 0);
      total++;
      if (stall_n != 10 || addr_err != 0)
         $display("FAIL stall_addr: %0d stall cycles %0d addr errors, need 10 and 0",
                  stall_n, addr_err);
      else pass_cnt++;
      total++;
      if (seq_errs() != 0 || stall_err != 0)
         $display("FAIL stall_seq: %0d pixel errors %0d unstable, need 0 and 0",
                  seq_errs(), stall_err);
      else pass_cnt++;
      total++;
      if (done_cyc != exp_done_cyc())
         $display("FAIL stall_done: cycle %0d, need %0d",
                  done_cyc, exp_done_cyc());
      else pass_cnt++;
   endtask

   task automatic test_abort();
      fill_random();
      build_model();
      ready = 1'b1;
      start_line();
      run(100, 0, 50);
      abort = 1'b1;
      ready = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0;
      ready = 1'b1;
      total++;
      if ({pif.pix_valid, busy, rd_addr} !== '0)
         $display("FAIL abort_idle: v=%b busy=%b addr=%0d, need 0 0 0",
                  pif.pix_valid, busy, rd_addr);
      else pass_cnt++;
      run(30, 0, 0);
      total++;
      if (done_cnt != 0 || got.size() != 0)
         $display("FAIL abort_quiet: %0d dones %0d pixels, need 0 and 0",
                  done_cnt, got.size());
      else pass_cnt++;
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      total++;
      if (busy !== 1'b0)
         $display("FAIL abort_wins: busy=%b, need 0", busy);
      else pass_cnt++;
      start_line();
      run(200, 0, 0);
      total++;
      if (seq_errs() != 0 || done_cnt != 1)
         $display("FAIL abort_restart: %0d pixel errors %0d dones, need 0 and 1",
                  seq_errs(), done_cnt);
      else pass_cnt++;
   endtask

   task automatic test_restart_ignored();
      fill_random();
      build_model();
      ready = 1'b1;
      start_line();
      run(300, 4, 0);
      total++;
      if (fired != 4)
         $display("FAIL restart_pulses: %0d sent, need 4", fired);
      else pass_cnt++;
      total++;
      if (done_cnt != 1 || seq_errs() != 0)
         $display("FAIL restart_once: %0d dones %0d pixel errors, need 1 and 0",
                  done_cnt, seq_errs());
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      fill_random();
      build_model();
      ready = 1'b1;
      start_line();
      run(100, 0, 30);
      #2 reset = 1'b1;
      #1;
      total++;
      if ({rd_addr, pif.pix_valid, pif.pix_data, pif.pix_last,
           busy, done} !== '0)
         $display("FAIL async_reset: addr=%0d v=%b d=%b l=%b b=%b dn=%b need all 0",
                  rd_addr, pif.pix_valid, pif.pix_data, pif.pix_last,
                  busy, done);
      else pass_cnt++;
      #2 reset = 1'b0;
      start_line();
      run(200, 0, 0);
      total++;
      if (seq_errs() != 0 || done_cnt != 1)
         $display("FAIL reset_restart: %0d pixel errors %0d dones, need 0 and 1",
                  seq_errs(), done_cnt);
      else pass_cnt++;
   endtask

   task automatic test_random_ready();
      for (int n = 0; n < 3; n++) begin
         fill_random();
         build_model();
         ready = 1'($urandom_range(0, 1));
         start_line();
         run(1000, 2, 0);
         total++;
         if (seq_errs() != 0 || stall_err != 0)
            $display("FAIL rand_seq%0d: %0d pixel errors %0d unstable, need 0 and 0",
                     n, seq_errs(), stall_err);
         else pass_cnt++;
         total++;
         if (done_cyc != exp_done_cyc() || done_cnt != 1)
            $display("FAIL rand_done%0d: cycle %0d count %0d, need cycle %0d count 1",
                     n, done_cyc, done_cnt, exp_done_cyc());
         else pass_cnt++;
         total++;
         if (lasts.size() != 1 || lasts[0] != NPIX - 1)
            $display("FAIL rand_last%0d: %0d last pulses, need 1 at %0d",
                     n, lasts.size(), NPIX - 1);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_toggle();
      test_stall();
      test_abort();
      test_restart_ignored();
      test_async_reset();
      test_random_ready();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
